// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add / shift-subtract engine sequenced by an FSM.
// Optional macro MULDIV_EARLY_OUT_EN lets zero-divisor, signed-overflow and zero-operand ops bypass CALC.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result,
  output logic            Stall
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic [2:0]        op_q;
  logic              neg_q, sa_q, bzero_q, busy_q, done_q;
  logic [XLEN-1:0]   absb_q, result_q, result_d;
  logic [2*XLEN-1:0] prod_q, prod_d, early_prod_s, mul_fix_s;
  logic [CNT_W-1:0]  cnt_q;

  logic            sgn_a_s, sgn_b_s, neg_a_s, neg_b_s, skip_s, div_ge_s;
  logic [XLEN-1:0] abs_a_s, abs_b_s;
  logic [XLEN:0]   mul_sum_s, div_shift_s, div_sub_s;

  // Operand signedness per M-extension op (MUL low word is sign-agnostic, so treat it as signed)
  always_comb begin
    sgn_a_s = 1'b0;
    sgn_b_s = 1'b0;
    case (Funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin sgn_a_s = 1'b1; sgn_b_s = 1'b1; end
      3'b010:                         begin sgn_a_s = 1'b1; sgn_b_s = 1'b0; end
      default:                        begin sgn_a_s = 1'b0; sgn_b_s = 1'b0; end
    endcase
  end

  assign neg_a_s = sgn_a_s & SrcA[XLEN-1];
  assign neg_b_s = sgn_b_s & SrcB[XLEN-1];
  assign abs_a_s = neg_a_s ? -SrcA : SrcA;
  assign abs_b_s = neg_b_s ? -SrcB : SrcB;

`ifdef MULDIV_EARLY_OUT_EN
  logic div_zero_s, div_ovf_s, mul_zero_s;
  assign div_zero_s = Funct3[2] & (SrcB == {XLEN{1'b0}});
  assign div_ovf_s  = Funct3[2] & ~Funct3[0] & (SrcA == {1'b1, {(XLEN-1){1'b0}}})
                    & (SrcB == {XLEN{1'b1}});
  assign mul_zero_s = ~Funct3[2] & ((SrcA == {XLEN{1'b0}}) | (SrcB == {XLEN{1'b0}}));
  assign skip_s     = div_zero_s | div_ovf_s | mul_zero_s;
  // Preload the product/remainder register so FIXUP produces the architected special value
  assign early_prod_s = div_zero_s ? {abs_a_s, {XLEN{1'b1}}} :
                        div_ovf_s  ? {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}} :
                                     {(2*XLEN){1'b0}};
`else
  assign skip_s       = 1'b0;
  assign early_prod_s = {(2*XLEN){1'b0}};
`endif

  // Upper half of prod_q is the partial product / remainder, lower half the multiplier / quotient
  assign mul_sum_s   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, absb_q} : {(XLEN+1){1'b0}});
  assign div_shift_s = prod_q[2*XLEN-1:XLEN-1];
  assign div_ge_s    = (div_shift_s >= {1'b0, absb_q});
  assign div_sub_s   = div_shift_s - {1'b0, absb_q};

  // One radix-2 iteration of the selected engine
  always_comb begin
    if (op_q[2]) begin
      prod_d = {(div_ge_s ? div_sub_s[XLEN-1:0] : div_shift_s[XLEN-1:0]), prod_q[XLEN-2:0], div_ge_s};
    end else begin
      prod_d = {mul_sum_s, prod_q[XLEN-1:1]};
    end
  end

  assign mul_fix_s = neg_q ? -prod_q : prod_q;

  // Sign fix-up and word selection; a zero divisor forces an all-ones quotient regardless of signs
  always_comb begin
    result_d = {XLEN{1'b0}};
    case (op_q)
      3'b000:                 result_d = mul_fix_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_d = mul_fix_s[2*XLEN-1:XLEN];
      3'b100, 3'b101: begin
        if (bzero_q) result_d = {XLEN{1'b1}};
        else         result_d = neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
      end
      3'b110, 3'b111:         result_d = sa_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
      default:                result_d = {XLEN{1'b0}};
    endcase
  end

  // Sequencer FSM with registered Busy/Done/Result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 3'b000;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      bzero_q  <= 1'b0;
      absb_q   <= {XLEN{1'b0}};
      prod_q   <= {(2*XLEN){1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {XLEN{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            op_q    <= Funct3;
            neg_q   <= neg_a_s ^ neg_b_s;
            sa_q    <= neg_a_s;
            bzero_q <= (SrcB == {XLEN{1'b0}});
            absb_q  <= abs_b_s;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b1;
            if (skip_s) begin
              prod_q  <= early_prod_s;
              state_q <= S_FIXUP;
            end else begin
              prod_q  <= {{XLEN{1'b0}}, abs_a_s};
              state_q <= S_CALC;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_CALC: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_W'(XLEN-1)) state_q <= S_FIXUP;
          else                         state_q <= S_CALC;
        end
        S_FIXUP: begin
          result_q <= result_d;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;
  assign Stall  = Start & ~done_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: results, latency, Stall/Busy, operand
// isolation, synchronous reset mid-operation and back-to-back issue.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] SrcA = 32'h0;
  logic [31:0] SrcB = 32'h0;
  logic        Busy, Done, Stall;
  logic [31:0] Result;

  int errors = 0;
  int checks = 0;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .Start(Start), .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB),
    .Busy(Busy), .Done(Done), .Result(Result), .Stall(Stall)
  );

  always #5 clk = ~clk;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        special;
  } vec_t;

  vec_t vecs [15] = '{
    '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0}, // MUL 7*-3
    '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0}, // MULHU
    '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0}, // MULH -1*-1
    '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0}, // MULHSU -1*2
    '{3'b000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b1}, // MUL by zero
    '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1}, // DIV overflow
    '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1}, // REM overflow
    '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0}, // DIV -7/2
    '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0}, // REM -7%2
    '{3'b101, 32'd100,       32'd7,         32'd14,        1'b0}, // DIVU
    '{3'b111, 32'd100,       32'd7,         32'd2,         1'b0}, // REMU
    '{3'b101, 32'd9,         32'd0,         32'hFFFF_FFFF, 1'b1}, // DIVU /0
    '{3'b111, 32'd5,         32'd0,         32'd5,         1'b1}, // REMU /0
    '{3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1'b1}, // DIV -7/0
    '{3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b1}  // REM -7/0
  };

  task automatic test_reset();
    reset = 1'b1;
    Start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", Done); end
    checks++; if (Result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", Result); end
    reset = 1'b0;
  endtask

  task automatic run_vectors(input int lo, input int hi);
    int n;
    int exp_lat;
    bit stall_ok;
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      Start = 1'b1; Funct3 = vecs[i].f3; SrcA = vecs[i].a; SrcB = vecs[i].b;
      @(posedge clk);
      n = 0; stall_ok = 1'b1;
      @(negedge clk);
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL busy[%0d] got %0b want 1", i, Busy); end
      while (Done !== 1'b1 && n < 60) begin
        if (Stall !== 1'b1) stall_ok = 1'b0;
        @(posedge clk); n++;
        @(negedge clk);
      end
      exp_lat = (EARLY && vecs[i].special) ? 2 : 34;
      checks++; if (n + 1 != exp_lat) begin errors++; $display("FAIL latency[%0d] got %0d want %0d", i, n + 1, exp_lat); end
      checks++; if (Result !== vecs[i].exp) begin errors++; $display("FAIL result[%0d] got %h want %h", i, Result, vecs[i].exp); end
      checks++; if (!stall_ok || Stall !== 1'b0) begin errors++; $display("FAIL stall[%0d] got ok=%0b done_stall=%0b want ok=1 done_stall=0", i, stall_ok, Stall); end
      Start = 1'b0;
    end
  endtask

  task automatic test_mul();      run_vectors(0, 4);   endtask
  task automatic test_div();      run_vectors(5, 10);  endtask
  task automatic test_div_zero(); run_vectors(11, 14); endtask

  task automatic test_operand_change();
    int n;
    int extra;
    @(negedge clk);
    Start = 1'b1; Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd5;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    while (Done !== 1'b1 && n < 60) begin
      if (n == 5) begin Funct3 = 3'b100; SrcA = 32'd100; SrcB = 32'd9; end
      @(posedge clk); n++;
      @(negedge clk);
    end
    checks++; if (n + 1 != 34) begin errors++; $display("FAIL latch_latency got %0d want 34", n + 1); end
    checks++; if (Result !== 32'd15) begin errors++; $display("FAIL latch_result got %h want %h", Result, 32'd15); end
    Start = 1'b0;
    extra = 0;
    repeat (40) begin @(posedge clk); @(negedge clk); if (Done === 1'b1) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL second_done got %0d want 0", extra); end
    checks++; if (Result !== 32'd15) begin errors++; $display("FAIL result_hold got %h want %h", Result, 32'd15); end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    Start = 1'b1; Funct3 = 3'b100; SrcA = 32'd1000; SrcB = 32'd3;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; Start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL midreset_done got %0b want 0", Done); end
    checks++; if (Result !== 32'h0) begin errors++; $display("FAIL midreset_result got %h want 0", Result); end
    reset = 1'b0;
    run_vectors(9, 9);
  endtask

  task automatic test_back_to_back();
    int n;
    run_vectors(0, 0);
    // Hold Start high through the Done cycle with a new instruction already presented
    Start = 1'b1; Funct3 = 3'b011; SrcA = 32'h0001_0000; SrcB = 32'h0001_0000;
    n = 0;
    @(posedge clk); n++;
    @(negedge clk);
    while (Done !== 1'b1 && n < 80) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    checks++; if (n != 35) begin errors++; $display("FAIL b2b_latency got %0d want 35", n); end
    checks++; if (Result !== 32'h0000_0001) begin errors++; $display("FAIL b2b_result got %h want 00000001", Result); end
    Start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_operand_change();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
